// File: rtl/data_tile_streamer.sv
// Scan-loaded tile memory that streams a block of tiles, NUM_CH per beat,
// over a valid/ready handshake with per-lane valid for the final group.
module data_tile_streamer #(
  parameter int NUM_CH    = 2,
  parameter int TILE      = 6,
  parameter int DW        = 14,
  parameter int MEM_DEPTH = 256,
  parameter int AW        = 8,
  parameter int WORD_W    = 512
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          scan_mode,
  input  logic [AW-1:0]                 scan_addr,
  input  logic [WORD_W-1:0]             scan_in,
  input  logic                          start_i,
  input  logic [AW-1:0]                 base_addr_i,
  input  logic [7:0]                    block_width_i,
  input  logic [7:0]                    block_height_i,
  input  logic                          size_type_i,
  output logic                          busy_o,
  output logic                          out_valid_o,
  input  logic                          out_ready_i,
  output logic [NUM_CH-1:0]             lane_valid_o,
  output logic [NUM_CH*TILE*TILE*DW-1:0] tile_o,
  output logic [NUM_CH*AW-1:0]          tile_addr_o,
  output logic                          size_type_o,
  output logic [15:0]                   block_cnt_o,
  output logic                          done_o
);

  localparam int TW = TILE*TILE*DW;

  typedef enum logic [1:0] {S_IDLE, S_STREAM, S_DONE} state_t;

  state_t r_state, w_state_nxt;

  logic [TW-1:0]        r_mem [MEM_DEPTH];
  logic [15:0]          r_total, r_idx, r_cnt;
  logic [AW-1:0]        r_gaddr;
  logic                 r_size, r_valid, r_busy, r_done;
  logic [NUM_CH-1:0]    r_lane_vld;
  logic [NUM_CH*TW-1:0] r_tile;
  logic [NUM_CH*AW-1:0] r_addr;

  logic [15:0]          w_total_in, w_ld_idx, w_ld_total;
  logic [AW-1:0]        w_ld_gaddr;
  logic                 w_ld_size, w_start, w_accept, w_more, w_load, w_done_nxt;
  logic [NUM_CH-1:0]    w_lane_vld;
  logic [NUM_CH*TW-1:0] w_lane_tile;
  logic [NUM_CH*AW-1:0] w_lane_addr;

  function automatic logic [TW-1:0] sub_mask(input logic [TW-1:0] t, input logic s);
    logic [TW-1:0] m;
    m = t;
    if (s) begin
      for (int r = 0; r < TILE; r++)
        for (int c = 0; c < TILE; c++)
          if (r >= TILE-2 || c >= TILE-2) m[(r*TILE+c)*DW +: DW] = '0;
    end
    return m;
  endfunction

  function automatic logic [15:0] popcount(input logic [NUM_CH-1:0] v);
    logic [15:0] n;
    n = '0;
    for (int k = 0; k < NUM_CH; k++) n = n + 16'(v[k]);
    return n;
  endfunction

  generate
    if (WORD_W > TW) begin : g_pad
      logic w_unused_scan_hi;
      assign w_unused_scan_hi = ^scan_in[WORD_W-1:TW];
    end
  endgenerate

  assign w_total_in = 16'(block_width_i) * 16'(block_height_i);
  assign w_start    = (r_state == S_IDLE) && start_i;
  assign w_accept   = (r_state == S_STREAM) && r_valid && out_ready_i;
  assign w_more     = (17'(r_idx) + 17'(NUM_CH)) < 17'(r_total);

  // Next-group source: group 0 of a new job, or the group after the current one
  assign w_ld_idx   = w_start ? 16'd0       : r_idx + 16'(NUM_CH);
  assign w_ld_gaddr = w_start ? base_addr_i : r_gaddr + AW'(NUM_CH);
  assign w_ld_total = w_start ? w_total_in  : r_total;
  assign w_ld_size  = w_start ? size_type_i : r_size;

  genvar k;
  generate
    for (k = 0; k < NUM_CH; k++) begin : g_lane
      logic [16:0]   w_i;
      logic [AW-1:0] w_a;
      assign w_i = 17'(w_ld_idx) + 17'(k);
      assign w_a = w_ld_gaddr + AW'(k);
      assign w_lane_vld[k]               = w_i < 17'(w_ld_total);
      assign w_lane_addr[k*AW +: AW]     = w_lane_vld[k] ? w_a : '0;
      assign w_lane_tile[k*TW +: TW]     = w_lane_vld[k] ? sub_mask(r_mem[w_a], w_ld_size) : '0;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_done_nxt  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start_i) begin
          if (w_total_in != 16'd0) begin
            w_state_nxt = S_STREAM;
            w_load      = 1'b1;
          end else begin
            w_done_nxt  = 1'b1;
          end
        end
      end
      S_STREAM: begin
        if (w_accept) begin
          if (w_more) begin
            w_load = 1'b1;
          end else begin
            w_state_nxt = S_DONE;
            w_done_nxt  = 1'b1;
          end
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Scan writes only land while idle; reads above see the pre-write contents
  always_ff @(posedge clk) begin
    if (scan_mode && r_state == S_IDLE) r_mem[scan_addr] <= scan_in[TW-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_total    <= '0;
      r_idx      <= '0;
      r_cnt      <= '0;
      r_gaddr    <= '0;
      r_size     <= 1'b0;
      r_valid    <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_lane_vld <= '0;
      r_tile     <= '0;
      r_addr     <= '0;
    end else begin
      r_done <= w_done_nxt;
      if (w_start) begin
        r_total <= w_total_in;
        r_size  <= size_type_i;
        r_cnt   <= '0;
      end
      if (w_accept) r_cnt <= r_cnt + popcount(r_lane_vld);
      if (w_load) begin
        r_idx      <= w_ld_idx;
        r_gaddr    <= w_ld_gaddr;
        r_lane_vld <= w_lane_vld;
        r_tile     <= w_lane_tile;
        r_addr     <= w_lane_addr;
        r_valid    <= 1'b1;
        r_busy     <= 1'b1;
      end else if (w_accept) begin
        r_valid <= 1'b0;
        r_busy  <= 1'b0;
      end
    end
  end

  assign busy_o       = r_busy;
  assign out_valid_o  = r_valid;
  assign lane_valid_o = r_lane_vld;
  assign tile_o       = r_tile;
  assign tile_addr_o  = r_addr;
  assign size_type_o  = r_size;
  assign block_cnt_o  = r_cnt;
  assign done_o       = r_done;

endmodule

// File: tb/tb_data_tile_streamer.sv
// Bench for data_tile_streamer: job table plus hand sequences, with a beat
// scoreboard filled at job start and drained as the consumer accepts beats.
module tb_data_tile_streamer;

  localparam int NUM_CH    = 2;
  localparam int TILE      = 6;
  localparam int DW        = 14;
  localparam int MEM_DEPTH = 256;
  localparam int AW        = 8;
  localparam int WORD_W    = 512;
  localparam int TW        = TILE*TILE*DW;
  localparam int BUDGET    = 2000;

  logic                   clk = 1'b0;
  logic                   reset, scan_mode, start_i, size_type_i, out_ready_i;
  logic [AW-1:0]          scan_addr, base_addr_i;
  logic [WORD_W-1:0]      scan_in;
  logic [7:0]             block_width_i, block_height_i;
  logic                   busy_o, out_valid_o, size_type_o, done_o;
  logic [NUM_CH-1:0]      lane_valid_o;
  logic [NUM_CH*TW-1:0]   tile_o;
  logic [NUM_CH*AW-1:0]   tile_addr_o;
  logic [15:0]            block_cnt_o;

  always #5 clk = ~clk;

  data_tile_streamer #(
    .NUM_CH(NUM_CH), .TILE(TILE), .DW(DW),
    .MEM_DEPTH(MEM_DEPTH), .AW(AW), .WORD_W(WORD_W)
  ) dut (
    .clk(clk), .reset(reset), .scan_mode(scan_mode), .scan_addr(scan_addr),
    .scan_in(scan_in), .start_i(start_i), .base_addr_i(base_addr_i),
    .block_width_i(block_width_i), .block_height_i(block_height_i),
    .size_type_i(size_type_i), .busy_o(busy_o), .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i), .lane_valid_o(lane_valid_o), .tile_o(tile_o),
    .tile_addr_o(tile_addr_o), .size_type_o(size_type_o),
    .block_cnt_o(block_cnt_o), .done_o(done_o)
  );

  typedef struct {
    logic [NUM_CH-1:0]    lv;
    logic [NUM_CH*AW-1:0] addr;
    logic [NUM_CH*TW-1:0] tile;
    logic                 size;
  } beat_t;

  typedef struct {
    int base; int w; int h; bit s; int rmode; bit bstart; int exp_cnt;
  } job_t;

  beat_t         sb[$];
  logic [TW-1:0] mdl [MEM_DEPTH];
  int            checks = 0;
  int            errors = 0;
  int            done_cnt = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [TW-1:0] pat(input int a);
    logic [TW-1:0] t;
    for (int r = 0; r < TILE; r++)
      for (int c = 0; c < TILE; c++)
        t[(r*TILE+c)*DW +: DW] = DW'(a + r*TILE + c);
    return t;
  endfunction

  function automatic logic [TW-1:0] exp_tile(input int a, input bit s);
    logic [TW-1:0] t;
    t = mdl[a];
    if (s)
      for (int r = 0; r < TILE; r++)
        for (int c = 0; c < TILE; c++)
          if (r > 3 || c > 3) t[(r*TILE+c)*DW +: DW] = '0;
    return t;
  endfunction

  task automatic scan(input int a, input logic [TW-1:0] d);
    scan_mode = 1'b1;
    scan_addr = AW'(a);
    scan_in   = {{(WORD_W-TW){1'b1}}, d};
    @(posedge clk); #1;
    scan_mode = 1'b0;
    mdl[a] = d;
  endtask

  task automatic push_job(input int base, input int w, input int h, input bit s);
    int total;
    total = w * h;
    for (int i = 0; i < total; i += NUM_CH) begin
      beat_t b;
      b.lv = '0; b.addr = '0; b.tile = '0; b.size = s;
      for (int k = 0; k < NUM_CH; k++) begin
        if (i + k < total) begin
          b.lv[k] = 1'b1;
          b.addr[k*AW +: AW] = AW'((base + i + k) % MEM_DEPTH);
          b.tile[k*TW +: TW] = exp_tile((base + i + k) % MEM_DEPTH, s);
        end
      end
      sb.push_back(b);
    end
  endtask

  task automatic issue_start(input int base, input int w, input int h, input bit s);
    start_i        = 1'b1;
    base_addr_i    = AW'(base);
    block_width_i  = 8'(w);
    block_height_i = 8'(h);
    size_type_i    = s;
    @(posedge clk); #1;
    start_i = 1'b0;
  endtask

  task automatic run_job(input job_t j);
    int cyc, d0, total;
    total = j.w * j.h;
    push_job(j.base, j.w, j.h, j.s);
    out_ready_i = 1'b1;
    d0 = done_cnt;
    issue_start(j.base, j.w, j.h, j.s);
    chk("busy_after_start", busy_o, (total != 0));
    cyc = 0;
    while (!done_o && cyc < BUDGET) begin
      out_ready_i = (j.rmode == 0) ? 1'b1 : ((cyc % 3) == 0);
      if (j.bstart && cyc == 2) begin
        start_i = 1'b1; base_addr_i = 8'd3; block_width_i = 8'd2; block_height_i = 8'd2;
      end else begin
        start_i = 1'b0;
      end
      @(posedge clk); #1;
      cyc++;
    end
    start_i = 1'b0;
    chk("done_timeout", (cyc >= BUDGET), 0);
    if (j.rmode == 0) chk("done_latency", cyc, (total + NUM_CH - 1) / NUM_CH);
    chk("block_cnt_final", block_cnt_o, j.exp_cnt);
    chk("sb_drained", sb.size(), 0);
    chk("busy_in_done", busy_o, 0);
    chk("valid_in_done", out_valid_o, 0);
    chk("size_type_latched", size_type_o, j.s);
    @(posedge clk); #1;
    chk("done_single_pulse", done_o, 0);
    chk("done_count", done_cnt - d0, 1);
    chk("block_cnt_hold", block_cnt_o, j.exp_cnt);
    sb.delete();
  endtask

  always @(negedge clk) begin
    if (done_o) done_cnt++;
    if (!reset && out_valid_o) begin
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_beat: got out_valid_o=1 expected 0");
      end else begin
        chk("lane_valid", lane_valid_o, sb[0].lv);
        chk("tile_addr", tile_addr_o, sb[0].addr);
        chk("beat_size_type", size_type_o, sb[0].size);
        for (int k = 0; k < NUM_CH; k++) begin
          checks++;
          if (tile_o[k*TW +: TW] !== sb[0].tile[k*TW +: TW]) begin
            errors++;
            $display("FAIL tile_lane%0d: got %h expected %h", k,
                     tile_o[k*TW +: TW], sb[0].tile[k*TW +: TW]);
          end
        end
        if (out_ready_i) void'(sb.pop_front());
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    job_t jobs[6];
    job_t jn;
    logic [TW-1:0] ones;
    int d0;

    jobs[0] = '{base: 0,   w: 5, h: 5, s: 0, rmode: 0, bstart: 0, exp_cnt: 25};
    jobs[1] = '{base: 0,   w: 5, h: 5, s: 0, rmode: 1, bstart: 0, exp_cnt: 25};
    jobs[2] = '{base: 250, w: 4, h: 2, s: 0, rmode: 0, bstart: 0, exp_cnt: 8};
    jobs[3] = '{base: 0,   w: 0, h: 7, s: 0, rmode: 0, bstart: 0, exp_cnt: 0};
    jobs[4] = '{base: 0,   w: 5, h: 5, s: 0, rmode: 0, bstart: 1, exp_cnt: 25};
    jobs[5] = '{base: 17,  w: 3, h: 3, s: 1, rmode: 1, bstart: 0, exp_cnt: 9};

    reset = 1'b1; scan_mode = 1'b0; start_i = 1'b0; size_type_i = 1'b0;
    out_ready_i = 1'b0; scan_addr = '0; base_addr_i = '0; scan_in = '0;
    block_width_i = '0; block_height_i = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", out_valid_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_lane_valid", lane_valid_o, 0);
    chk("rst_addr", tile_addr_o, 0);
    chk("rst_cnt", block_cnt_o, 0);
    chk("rst_tile_zero", |tile_o, 0);
    reset = 1'b0;

    for (int a = 0; a < MEM_DEPTH; a++) scan(a, pat(a));

    foreach (jobs[i]) run_job(jobs[i]);

    // Sub-tile masking on a tile of all 0x1FFF
    for (int e = 0; e < TILE*TILE; e++) ones[e*DW +: DW] = 14'h1FFF;
    scan(100, ones);
    jn = '{base: 100, w: 1, h: 1, s: 1, rmode: 0, bstart: 0, exp_cnt: 1};
    run_job(jn);
    scan(100, pat(100));

    // Reset in the middle of a job, after three accepted beats
    push_job(0, 5, 5, 0);
    out_ready_i = 1'b1;
    issue_start(0, 5, 5, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("mid_cnt_before_reset", block_cnt_o, 6);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    sb.delete();
    d0 = done_cnt;
    chk("abort_valid", out_valid_o, 0);
    chk("abort_busy", busy_o, 0);
    chk("abort_done", done_o, 0);
    chk("abort_lane_valid", lane_valid_o, 0);
    chk("abort_addr", tile_addr_o, 0);
    chk("abort_cnt", block_cnt_o, 0);
    chk("abort_tile_zero", |tile_o, 0);
    repeat (4) @(posedge clk);
    #1;
    chk("abort_no_done", done_cnt - d0, 0);
    run_job(jobs[0]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
